// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives
// the ALU op code, operand/PC/writeback selects and write strobes.
// Its only state is the FSM state and the sticky illegal-instruction flag.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   instr               - instruction from the IR (valid from DECODE on)
//   bcond               - branch condition from the execute unit (EXEC)
//   mem_ready           - completion of the current mem_req
//   alu_op              - 5-bit op code, MSB=1 for branch/JALR/LUI
//   alu_src_a/b         - operand selects
//   pc_src, wb_sel      - PC source / writeback source selects
//   pc_write, ir_write, reg_write, mem_req, mem_we - strobes
//   mem_addr_sel        - 0=PC (fetch), 1=ALU out (data)
//   state               - FSM state code
//   retired             - one-cycle pulse per completed instruction
//   illegal_instr       - sticky trap flag
module multicycle_ctrl #(
  parameter int unsigned ALU_CTRL_WIDTH = 5,
  parameter int unsigned INSTR_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [INSTR_WIDTH-1:0]    instr,
  input  logic                      bcond,
  input  logic                      mem_ready,
  output logic [ALU_CTRL_WIDTH-1:0] alu_op,
  output logic [1:0]                alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [1:0]                pc_src,
  output logic [1:0]                wb_sel,
  output logic                      pc_write,
  output logic                      ir_write,
  output logic                      reg_write,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic                      mem_addr_sel,
  output logic [2:0]                state,
  output logic                      retired,
  output logic                      illegal_instr
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] SRC_A_RS1 = 2'd0;
  localparam logic [1:0] SRC_A_PC  = 2'd1;
  localparam logic [1:0] SRC_B_RS2 = 2'd0;
  localparam logic [1:0] SRC_B_IMM = 2'd1;
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic legal, br_bad;

  logic [ALU_CTRL_WIDTH-1:0] alu_op_x;
  logic [1:0]                src_a_x, src_b_x;

  // rs1/rs2/immediate fields belong to the datapath, not to control
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instr[INSTR_WIDTH-1], instr[29:15]};

  // Instruction class decode
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign rd       = instr[11:7];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LOAD);
  assign is_st    = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
  // funct3 010/011 are not defined for branches
  assign br_bad   = is_br && (funct3[2:1] == 2'b01);

  // ALU op and operand selects; held unchanged through EXEC, MEM and WB
  always_comb begin
    alu_op_x = '0;
    src_a_x  = SRC_A_RS1;
    src_b_x  = SRC_B_RS2;
    if (is_r) begin
      alu_op_x = ALU_CTRL_WIDTH'({1'b0, instr[30], funct3});
    end else if (is_i) begin
      // only the shift-right pair uses instr[30] to pick arithmetic vs logical
      alu_op_x = ALU_CTRL_WIDTH'({1'b0, (funct3 == 3'b101) ? instr[30] : 1'b0, funct3});
      src_b_x  = SRC_B_IMM;
    end else if (is_ld || is_st) begin
      src_b_x  = SRC_B_IMM;
    end else if (is_br) begin
      alu_op_x = ALU_CTRL_WIDTH'({2'b10, funct3});
    end else if (is_jalr) begin
      alu_op_x = ALU_CTRL_WIDTH'(5'b11001);
      src_b_x  = SRC_B_IMM;
    end else if (is_lui) begin
      alu_op_x = ALU_CTRL_WIDTH'(5'b11000);
      src_b_x  = SRC_B_IMM;
    end else if (is_auipc) begin
      src_a_x  = SRC_A_PC;
      src_b_x  = SRC_B_IMM;
    end
  end

  // State register and sticky trap flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_br)              state_d = br_bad ? S_TRAP : S_FETCH;
        else if (is_ld || is_st) state_d = S_MEM;
        else                    state_d = S_WB;
      end
      S_MEM:    if (mem_ready) state_d = is_st ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic; everything forced quiet while reset is held
  always_comb begin
    alu_op       = '0;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = SRC_B_RS2;
    pc_src       = PC_PLUS4;
    wb_sel       = WB_ALU;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    retired      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        S_EXEC: begin
          alu_op    = alu_op_x;
          alu_src_a = src_a_x;
          alu_src_b = src_b_x;
          if (is_br && !br_bad) begin
            pc_write = 1'b1;
            pc_src   = bcond ? PC_TARGET : PC_PLUS4;
            retired  = 1'b1;
          end
        end
        S_MEM: begin
          alu_op       = alu_op_x;
          alu_src_a    = src_a_x;
          alu_src_b    = src_b_x;
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_st;
          if (mem_ready && is_st) begin
            pc_write = 1'b1;
            retired  = 1'b1;
          end
        end
        S_WB: begin
          alu_op    = alu_op_x;
          alu_src_a = src_a_x;
          alu_src_b = src_b_x;
          reg_write = (rd != 5'd0);
          pc_write  = 1'b1;
          retired   = 1'b1;
          if (is_ld) begin
            wb_sel = WB_MEM;
          end else if (is_jal) begin
            wb_sel = WB_PC4;
            pc_src = PC_TARGET;
          end else if (is_jalr) begin
            wb_sel = WB_PC4;
            pc_src = PC_ALU;
          end
        end
        default: ;
      endcase
    end
  end

  assign state         = state_q;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed instruction table, reset corner
// cases and randomized instruction streams against a phase-level model.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        bcond;
  logic        mem_ready;
  logic [4:0]  alu_op;
  logic [1:0]  alu_src_a, alu_src_b, pc_src, wb_sel;
  logic        pc_write, ir_write, reg_write, mem_req, mem_we, mem_addr_sel;
  logic [2:0]  state;
  logic        retired, illegal_instr;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .bcond(bcond), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .wb_sel(wb_sel), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .state(state), .retired(retired),
    .illegal_instr(illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {P_F = 3'd0, P_D = 3'd1, P_E = 3'd2, P_M = 3'd3, P_W = 3'd4, P_T = 3'd7} ph_e;
  typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD} cls_e;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] alu;
    logic [1:0] sa, sb, ps, wb;
    logic pcw, irw, rw, mreq, mwe, mas, ret, ill;
  } obs_t;

  typedef struct {
    logic [31:0] ins;
    int wf, wm;
    logic bc;
    int lat;
    logic [4:0] alu;
    logic [1:0] sb, ps, wb;
    logic rw, ill;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc, obs_lat;
  logic [4:0] obs_alu;
  logic [1:0] obs_sb, obs_ps, obs_wb;
  logic obs_rw, obs_ill, mdl_trap;

  function automatic cls_e cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_BAD;
    endcase
  endfunction

  // ALU op code from the instruction semantics, plain arithmetic on fields
  function automatic logic [4:0] alu_of(input logic [31:0] ins);
    int b30, f3, v;
    cls_e c;
    b30 = int'(ins[30]);
    f3  = int'(ins[14:12]);
    c   = cls_of(ins[6:0]);
    v = 0;
    if (c == C_R) v = 8 * b30 + f3;
    else if (c == C_I) v = f3 + ((f3 == 5) ? 8 * b30 : 0);
    else if (c == C_BR) v = 16 + f3;
    else if (c == C_JALR) v = 25;
    else if (c == C_LUI) v = 24;
    return 5'(v);
  endfunction

  function automatic obs_t exp_out(input ph_e ph, input logic [31:0] ins, input logic mr, input logic bc);
    obs_t e;
    cls_e c;
    int f3;
    c  = cls_of(ins[6:0]);
    f3 = int'(ins[14:12]);
    e = '0;
    e.st = ph;
    if (ph == P_E || ph == P_M || ph == P_W) begin
      e.alu = alu_of(ins);
      e.sa  = (c == C_AUIPC) ? 2'd1 : 2'd0;
      e.sb  = (c == C_R || c == C_BR || c == C_JAL) ? 2'd0 : 2'd1;
    end
    case (ph)
      P_F: begin e.mreq = 1'b1; e.irw = mr; end
      P_E: if (c == C_BR && f3 != 2 && f3 != 3) begin
        e.pcw = 1'b1; e.ps = bc ? 2'd1 : 2'd0; e.ret = 1'b1;
      end
      P_M: begin
        e.mreq = 1'b1; e.mas = 1'b1; e.mwe = (c == C_ST);
        if (mr && c == C_ST) begin e.pcw = 1'b1; e.ret = 1'b1; end
      end
      P_W: begin
        e.rw = (ins[11:7] != 5'd0); e.pcw = 1'b1; e.ret = 1'b1;
        e.wb = (c == C_LD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
        e.ps = (c == C_JAL) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
      end
      P_T: e.ill = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t act();
    obs_t a;
    a = {state, alu_op, alu_src_a, alu_src_b, pc_src, wb_sel, pc_write, ir_write,
         reg_write, mem_req, mem_we, mem_addr_sel, retired, illegal_instr};
    return a;
  endfunction

  task automatic check(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, a, e);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, a, e);
    end
  endtask

  // One clock: drive inputs at negedge, compare outputs just after
  task automatic do_cycle(input ph_e ph, input logic [31:0] ins, input logic mr, input logic bc);
    obs_t a, e;
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = mr;
    bcond     = (ph == P_E) ? bc : 1'($urandom);
    instr     = (ph == P_F) ? $urandom : ins;
    #1;
    a = act();
    e = exp_out(ph, ins, mr, bc);
    check($sformatf("cycle ins=%h ph=%0d", ins, ph), a, e);
    cyc++;
    if (a.ret) begin obs_lat = cyc; obs_ps = a.ps; obs_wb = a.wb; obs_rw = a.rw; end
    if (ph == P_E) begin obs_alu = a.alu; obs_sb = a.sb; end
    obs_ill = a.ill;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic bc);
    cls_e c;
    logic bad_br;
    c = cls_of(ins[6:0]);
    bad_br = (c == C_BR) && (ins[14:13] == 2'b01);
    cyc = 0; obs_lat = 0; obs_alu = '0; obs_sb = '0; obs_ps = '0; obs_wb = '0;
    obs_rw = 1'b0; mdl_trap = 1'b0;
    for (int i = 0; i <= wf; i++) do_cycle(P_F, ins, (i == wf), 1'b0);
    do_cycle(P_D, ins, 1'($urandom), 1'b0);
    if (c == C_BAD) begin
      mdl_trap = 1'b1;
      repeat (3) do_cycle(P_T, ins, 1'($urandom), 1'b0);
      return;
    end
    do_cycle(P_E, ins, 1'($urandom), bc);
    if (bad_br) begin
      mdl_trap = 1'b1;
      repeat (3) do_cycle(P_T, ins, 1'($urandom), 1'b0);
      return;
    end
    if (c == C_BR) return;
    if (c == C_LD || c == C_ST) begin
      for (int i = 0; i <= wm; i++) do_cycle(P_M, ins, (i == wm), 1'b0);
      if (c == C_ST) return;
    end
    do_cycle(P_W, ins, 1'($urandom), 1'b0);
  endtask

  // Two reset cycles: outputs quiet while asserted, FETCH/clear after the edge
  task automatic do_reset(input logic known, input ph_e st0, input logic ill0);
    obs_t a, e;
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'($urandom); bcond = 1'($urandom); instr = $urandom;
    #1;
    a = act(); e = '0;
    if (known) begin e.st = st0; e.ill = ill0; end
    else begin a.st = '0; a.ill = 1'b0; end
    check("reset_asserted", a, e);
    @(negedge clk);
    #1;
    a = act(); e = '0;
    check("reset_after_edge", a, e);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int k;
    ins = $urandom;
    k = $urandom_range(0, 19);
    case (k)
      0, 1, 16:   ins[6:0] = 7'b0110011;
      2, 3, 18:   ins[6:0] = 7'b0010011;
      4, 5:       ins[6:0] = 7'b0000011;
      6, 7:       ins[6:0] = 7'b0100011;
      8, 9, 10:   ins[6:0] = 7'b1100011;
      11:         ins[6:0] = 7'b1101111;
      12:         ins[6:0] = 7'b1100111;
      13:         ins[6:0] = 7'b0110111;
      14:         ins[6:0] = 7'b0010111;
      17:         begin ins[6:0] = 7'b0110011; ins[11:7] = 5'd0; end
      19:         begin ins[6:0] = 7'b0010011; ins[14:12] = 3'b101; end
      default:    ins[6:0] = 7'b1111111;
    endcase
    return ins;
  endfunction

  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t a, e;
    reset = 1'b1; instr = '0; bcond = 1'b0; mem_ready = 1'b0;

    //           ins            wf wm bc    lat alu       sb    ps    wb    rw    ill
    vecs[0]  = '{32'h402081B3, 0, 0, 1'b0, 4, 5'b01000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0}; // sub
    vecs[1]  = '{32'h40335293, 0, 0, 1'b0, 4, 5'b01101, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0}; // srai
    vecs[2]  = '{32'h00500093, 0, 0, 1'b0, 4, 5'b00000, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0}; // addi
    vecs[3]  = '{32'h0040A183, 2, 3, 1'b0, 10, 5'b00000, 2'd1, 2'd0, 2'd1, 1'b1, 1'b0}; // lw
    vecs[4]  = '{32'h00208463, 0, 0, 1'b1, 3, 5'b10000, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0}; // beq taken
    vecs[5]  = '{32'h00209463, 0, 0, 1'b0, 3, 5'b10001, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0}; // bne not taken
    vecs[6]  = '{32'h000280E7, 0, 0, 1'b0, 4, 5'b11001, 2'd1, 2'd2, 2'd2, 1'b1, 1'b0}; // jalr
    vecs[7]  = '{32'h0020A423, 0, 0, 1'b0, 4, 5'b00000, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0}; // sw
    vecs[8]  = '{32'h123452B7, 0, 0, 1'b0, 4, 5'b11000, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0}; // lui
    vecs[9]  = '{32'h00001397, 0, 0, 1'b0, 4, 5'b00000, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0}; // auipc
    vecs[10] = '{32'h010000EF, 0, 0, 1'b0, 4, 5'b00000, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0}; // jal
    vecs[11] = '{32'h00208033, 0, 0, 1'b0, 4, 5'b00000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0}; // add x0
    vecs[12] = '{32'hFFFFFFFF, 0, 0, 1'b0, 0, 5'b00000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1}; // bad opcode
    vecs[13] = '{32'h0020A463, 0, 0, 1'b0, 0, 5'b10010, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1}; // branch f3=010
    vecs[14] = '{32'h0020A423, 1, 2, 1'b0, 7, 5'b00000, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0}; // sw with waits

    do_reset(1'b0, P_F, 1'b0);

    for (int v = 0; v < 15; v++) begin
      run_instr(vecs[v].ins, vecs[v].wf, vecs[v].wm, vecs[v].bc);
      check_int($sformatf("vec%0d latency", v), obs_lat, vecs[v].lat);
      check_int($sformatf("vec%0d exec_alu_op", v), int'(obs_alu), int'(vecs[v].alu));
      check_int($sformatf("vec%0d exec_src_b", v), int'(obs_sb), int'(vecs[v].sb));
      check_int($sformatf("vec%0d retire_pc_src", v), int'(obs_ps), int'(vecs[v].ps));
      check_int($sformatf("vec%0d retire_wb_sel", v), int'(obs_wb), int'(vecs[v].wb));
      check_int($sformatf("vec%0d retire_reg_write", v), int'(obs_rw), int'(vecs[v].rw));
      check_int($sformatf("vec%0d illegal_instr", v), int'(obs_ill), int'(vecs[v].ill));
      if (vecs[v].ill) do_reset(1'b1, P_T, 1'b1);
    end

    // Reset in the middle of a store's data handshake
    cyc = 0;
    do_cycle(P_F, 32'h0020A423, 1'b1, 1'b0);
    do_cycle(P_D, 32'h0020A423, 1'b0, 1'b0);
    do_cycle(P_E, 32'h0020A423, 1'b0, 1'b0);
    do_cycle(P_M, 32'h0020A423, 1'b0, 1'b0);
    do_cycle(P_M, 32'h0020A423, 1'b0, 1'b0);
    do_reset(1'b1, P_M, 1'b0);
    do_cycle(P_F, 32'h00500093, 1'b0, 1'b0);

    // Reset in the middle of a stalled fetch
    do_cycle(P_F, 32'h00500093, 1'b0, 1'b0);
    do_reset(1'b1, P_F, 1'b0);

    // Trap holds until reset regardless of mem_ready
    run_instr(32'h0000007F, 1, 0, 1'b0);
    repeat (4) do_cycle(P_T, 32'h0000007F, 1'b1, 1'b0);
    do_reset(1'b1, P_T, 1'b1);

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ins;
      ins = gen_instr();
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      if (mdl_trap) do_reset(1'b1, P_T, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
